// File: rtl/gray_stream_source_pkg.sv
// Shared raster timing definitions: 640x480@60 defaults, total-span helper and run-state enum.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_ADDR_W   = 19;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/gray_stream_source_if.sv
// Pixel stream bundle between the grayscale source and the 3x3 window generator.
interface gray_stream_source_if;
  logic [7:0] data_out;
  logic       clken;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (output data_out, clken, hsync, vsync, frame_start);
  modport slave  (input  data_out, clken, hsync, vsync, frame_start);
endinterface

// File: rtl/gray_stream_source_raster_counter.sv
// Horizontal/vertical raster position counters with active, sync and frame-end decode.
module raster_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HC_W    = $clog2(H_TOTAL),
  localparam int VC_W    = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            active,
  output logic            hs_pulse,
  output logic            vs_pulse,
  output logic            frame_end
);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (advance) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + VC_W'(1);
      end else begin
        hc <= hc + HC_W'(1);
      end
    end
  end

  assign active    = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
  assign hs_pulse  = (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_pulse  = (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_end = (hc == H_LAST) && (vc == V_LAST);

endmodule

// File: rtl/gray_stream_source.sv
// Frame-timed grayscale pixel source: run/idle control, ROM address generation and a
// two-stage alignment pipeline so that pixel data and all stream flags leave together.
module gray_stream_source
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  gray_stream_source_if.master px
);

  localparam int HC_W = $clog2(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VC_W = $clog2(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t          state_reg;
  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;
  logic            active, hs_pulse, vs_pulse, frame_end;
  logic            advance, at_origin;
  logic            act_d1_reg, hs_d1_reg, vs_d1_reg, first_d1_reg;

  assign advance   = (state_reg == RUN);
  assign at_origin = (hc == '0) && (vc == '0);

  raster_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .hc        (hc),
    .vc        (vc),
    .active    (active),
    .hs_pulse  (hs_pulse),
    .vs_pulse  (vs_pulse),
    .frame_end (frame_end)
  );

  // en only matters in IDLE or on the last clock of a frame, so frames are never cut short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (en) state_reg <= RUN;
        RUN:     if (frame_end && !en) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Address tracks the counter position so the ROM's one-clock latency lands in stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (advance) begin
      if (frame_end)
        rom_addr <= '0;
      else if (active && rom_addr != ADDR_LAST)
        rom_addr <= rom_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d1_reg   <= 1'b0;
      hs_d1_reg    <= 1'b0;
      vs_d1_reg    <= 1'b0;
      first_d1_reg <= 1'b0;
    end else begin
      act_d1_reg   <= advance && active;
      hs_d1_reg    <= advance && hs_pulse;
      vs_d1_reg    <= advance && vs_pulse;
      first_d1_reg <= advance && at_origin;
    end
  end

  // Gate data with the valid flag so blanking never shows stale ROM contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px.data_out    <= 8'd0;
      px.clken       <= 1'b0;
      px.hsync       <= 1'b1;
      px.vsync       <= 1'b1;
      px.frame_start <= 1'b0;
    end else begin
      px.data_out    <= act_d1_reg ? rom_rdata : 8'd0;
      px.clken       <= act_d1_reg;
      px.hsync       <= ~hs_d1_reg;
      px.vsync       <= ~vs_d1_reg;
      px.frame_start <= first_d1_reg;
    end
  end

endmodule

// File: doc/gray_stream_source.md
# gray_stream_source

Frame-timed 8-bit grayscale pixel source that produces the `data_in`/`clken` stream consumed by the 3x3 window generator, plus active-low hsync/vsync.
- Walks a raster timing (active, front porch, sync, back porch) in both axes.
- Fetches pixels from a single-port image ROM with 1-cycle read latency.
- Emits one pixel per clock during active area, with `clken` high exactly on those cycles.
- Sits between the picture ROM and the filter pipeline, on the writer end of the `data_in`/`clken` interface.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `ADDR_W`, 19: ROM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE

Ports:
- `clk`  in  1: single clock
- `rst_n`  in  1: reset, asynchronous, active-low
- `en`  in  1: run request; sampled only at frame boundaries
- `rom_addr`  out  ADDR_W: registered ROM read address
- `rom_rdata`  in  8: ROM data, valid one clock after `rom_addr`
- `data_out`  out  8: pixel, drives filter `data_in`
- `clken`  out  1: pixel valid, drives filter `clken`
- `hsync`  out  1: active-low line sync
- `vsync`  out  1: active-low frame sync
- `frame_start`  out  1: one-cycle pulse, coincident with first `clken` of a frame

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Horizontal counter `hc` runs 0..H_TOTAL-1. Vertical counter `vc` runs 0..V_TOTAL-1 and increments when `hc` wraps.
- Active region: `hc` < H_ACTIVE and `vc` < V_ACTIVE.
- hsync is low for H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on `vc`.
- FSM states:
  - IDLE: counters held at 0, all outputs inactive. Moves to RUN on the first cycle `en`=1.
  - RUN: counters advance every clock. At `hc`=H_TOTAL-1, `vc`=V_TOTAL-1:
    - `en`=1: wrap to 0/0 and stay in RUN.
    - `en`=0: go to IDLE.
    - Deasserting `en` mid-frame never truncates the frame.
- ROM address:
  - Cleared to 0 at `hc`=0, `vc`=0.
  - Increments by 1 after each active pixel.
  - Holds outside the active region.
  - Final address is H_ACTIVE·V_ACTIVE-1; never wraps within a frame.
- Counter widths: clog2(H_TOTAL) and clog2(V_TOTAL). No arithmetic overflow is permitted.
- `data_out` is 0 whenever `clken`=0; it never leaks stale ROM data.

## Timing
- Stage 0: counters.
- Stage 1: registers `rom_addr`, plus delayed active/hs/vs/first flags.
- Stage 2: registers `data_out` <= `rom_rdata`, `clken`, `hsync`, `vsync`, `frame_start`.
- All stream outputs therefore lag the counter position by exactly 2 clocks, and are mutually aligned.
- Reset values:
  - `rom_addr`=0, `data_out`=0, `clken`=0, `frame_start`=0
  - `hsync`=1, `vsync`=1
  - state IDLE, counters 0
- From `en` rising in IDLE:
  - Counters leave 0 on the next clock.
  - First `clken`/`frame_start` appears 2 clocks after RUN is entered.
- Per frame:
  - Exactly H_ACTIVE consecutive `clken` cycles per active line.
  - Exactly V_ACTIVE·H_ACTIVE `clken` cycles in total.
- `rst_n` low mid-frame: all registers return to reset values immediately, with no partial-line flush. After release, the block restarts from IDLE.
- Back-to-back frames: no gap beyond the blanking intervals.
- On entering IDLE: the 2-stage pipeline drains the last blanking samples, then outputs hold inactive.

## Structure
- Shared package `vga_timing_pkg`:
  - Default timing constants (640x480@60).
  - Derived H_TOTAL/V_TOTAL function.
  - State enum {IDLE, RUN}.
- Natural sub-module: `raster_counter`. Contains the hc/vc counters, the active/hsync/vsync decode, and the frame-end flag. Parameterised by the timing constants and reused by the display side.
- The top level adds the FSM, ROM addressing and the alignment pipeline.

## Test plan
Bench uses H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, and a ROM model returning data=addr+1 with 1-cycle latency.
- Reset, `en`=0 for 50 clocks -> `clken`=0, `hsync`=`vsync`=1, `rom_addr`=0 throughout.
- Assert `en` held high -> `frame_start` on first `clken`. `data_out` sequence 1..12. Four `clken` per line with 4-clock gaps. hsync low 2 clocks per line at relative offset 5. vsync low for 8 clocks.
- Second frame back-to-back -> `data_out` restarts at 1 exactly H_TOTAL·V_TOTAL=48 clocks after the previous `frame_start`.
- Drop `en` during line 1 of a frame -> that frame completes with all 12 pixels, then outputs stay inactive and no further `frame_start` occurs.
- Pulse `rst_n` low during pixel 6 -> all outputs at reset values the same cycle. With `en`=1 after release, the next frame starts at `data_out`=1.
- Random back-pressure-free soak over 20 frames -> `clken` count=240. `data_out`=0 whenever `clken`=0.
